// File: rtl/multi_cycle_core_if.sv
// Unified memory port between multi_cycle_core and its memory.
// One request (read or write) is held until mem_ready completes it.
interface multi_cycle_core_if #(
    parameter int MEM_ADDR_W = 32
);
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multi_cycle_core.sv
// Multi-cycle MIPS-subset core on a single memory port (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module multi_cycle_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_ADDR_W = 32,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                rst,
    multi_cycle_core_if.master  bus,
    output logic [31:0]         pc_out,
    output logic [5:0]          opCode,
`ifdef PERF_CNT_EN
    output logic [31:0]         cycle_cnt,
    output logic [31:0]         instr_cnt,
`endif
    output logic                halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr, r_tgt, r_wait;
    logic [31:0] r_rf [32];

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [31:0] w_simm, w_res, w_pc_nx, w_addr;
    logic        w_ill, w_pc_we, w_link, w_lw;
    logic        w_rd_req, w_wr_req, w_req, w_done, w_tmo;
    state_t      w_xnext;

    assign w_op   = r_ir[31:26];
    assign w_fn   = r_ir[5:0];
    assign w_rs   = r_ir[25:21];
    assign w_rt   = r_ir[20:16];
    assign w_rd   = r_ir[15:11];
    assign w_simm = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_lw   = (w_op == 6'h23);

    always_comb begin
        w_res   = '0;
        w_ill   = 1'b0;
        w_xnext = S_FETCH;
        w_pc_we = 1'b0;
        w_pc_nx = r_pc;
        w_link  = 1'b0;
        unique case (w_op)
            6'h00: begin
                unique case (w_fn)
                    6'h20: begin w_res = r_a + r_b; w_xnext = S_WB; end
                    6'h22: begin w_res = r_a - r_b; w_xnext = S_WB; end
                    6'h24: begin w_res = r_a & r_b; w_xnext = S_WB; end
                    6'h25: begin w_res = r_a | r_b; w_xnext = S_WB; end
                    6'h2A: begin
                        w_res   = {31'b0, $signed(r_a) < $signed(r_b)};
                        w_xnext = S_WB;
                    end
                    6'h08: begin w_pc_we = 1'b1; w_pc_nx = r_a; end
                    default: w_ill = 1'b1;
                endcase
            end
            6'h08: begin w_res = r_a + w_simm; w_xnext = S_WB; end
            6'h0A: begin
                w_res   = {31'b0, $signed(r_a) < $signed(w_simm)};
                w_xnext = S_WB;
            end
            6'h23, 6'h2B: begin w_res = r_a + w_simm; w_xnext = S_MEM; end
            6'h04: begin w_pc_we = (r_a == r_b); w_pc_nx = r_tgt; end
            6'h05: begin w_pc_we = (r_a != r_b); w_pc_nx = r_tgt; end
            6'h02, 6'h03: begin
                w_pc_we = 1'b1;
                w_pc_nx = {r_pc[31:28], r_ir[25:0], 2'b00};
                w_link  = (w_op == 6'h03);
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Timeout counts the cycle in progress, so TIMEOUT=N traps after N stalls.
    assign w_req  = w_rd_req | w_wr_req;
    assign w_done = w_req & bus.mem_ready;
    assign w_tmo  = (TIMEOUT != 0) && !bus.mem_ready &&
                    ((r_wait + 32'd1) >= 32'(TIMEOUT));

    always_comb begin
        w_next   = r_state;
        w_rd_req = 1'b0;
        w_wr_req = 1'b0;
        w_addr   = r_pc;
        unique case (r_state)
            S_FETCH: begin
                w_rd_req = 1'b1;
                if (bus.mem_ready) w_next = S_DECODE;
                else if (w_tmo)    w_next = S_TRAP;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC:   w_next = w_ill ? S_TRAP : w_xnext;
            S_MEM: begin
                w_addr   = r_alu;
                w_rd_req = w_lw;
                w_wr_req = !w_lw;
                if (bus.mem_ready) w_next = w_lw ? S_WB : S_FETCH;
                else if (w_tmo)    w_next = S_TRAP;
            end
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc   <= RESET_PC;
            r_ir   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_alu  <= '0;
            r_mdr  <= '0;
            r_tgt  <= '0;
            r_wait <= '0;
        end else begin
            r_wait <= (w_req && !bus.mem_ready) ? r_wait + 32'd1 : '0;
            unique case (r_state)
                S_FETCH: if (w_done) begin
                    r_ir <= bus.mem_rdata;
                    r_pc <= r_pc + 32'd4;
                end
                S_DECODE: begin
                    r_a   <= (w_rs == 5'd0) ? '0 : r_rf[w_rs];
                    r_b   <= (w_rt == 5'd0) ? '0 : r_rf[w_rt];
                    r_tgt <= r_pc + {w_simm[29:0], 2'b00};
                end
                S_EXEC: begin
                    r_alu <= w_res;
                    if (w_pc_we) r_pc <= w_pc_nx;
                end
                S_MEM: if (w_done && w_lw) r_mdr <= bus.mem_rdata;
                default: ;
            endcase
        end
    end

    // Register file has no reset; reg[0] is never written and reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == S_EXEC && w_link && !w_ill)
                r_rf[31] <= r_pc;
            if (r_state == S_WB) begin
                if (w_lw) begin
                    if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
                end else if (w_op == 6'h00) begin
                    if (w_rd != 5'd0) r_rf[w_rd] <= r_alu;
                end else begin
                    if (w_rt != 5'd0) r_rf[w_rt] <= r_alu;
                end
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] r_cyc, r_ins;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cyc <= '0;
            r_ins <= '0;
        end else begin
            if (r_state != S_TRAP) r_cyc <= r_cyc + 32'd1;
            if ((r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) &&
                w_next == S_FETCH)
                r_ins <= r_ins + 32'd1;
        end
    end
    assign cycle_cnt = r_cyc;
    assign instr_cnt = r_ins;
`endif

    // Requests and halted are dropped combinationally while reset is held.
    assign bus.mem_read  = w_rd_req & rst;
    assign bus.mem_write = w_wr_req & rst;
    assign bus.mem_addr  = w_addr[MEM_ADDR_W-1:0];
    assign bus.mem_wdata = r_b;
    assign pc_out        = r_pc;
    assign opCode        = r_ir[31:26];
    assign halted        = (r_state == S_TRAP) & rst;

endmodule

// File: tb/tb_multi_cycle_core.sv
// Bench for multi_cycle_core: directed programs plus random programs
// checked against an instruction-level interpreter of the ISA.
module tb_multi_cycle_core;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_core_if #(.MEM_ADDR_W(32)) bus ();
    multi_cycle_core_if #(.MEM_ADDR_W(32)) tbus ();

    logic [31:0] pc_out, pc_out2;
    logic [5:0]  opc, opc2;
    logic        halted, halted2;
`ifdef PERF_CNT_EN
    logic [31:0] cc, ic, cc2, ic2;
`endif

    multi_cycle_core #(.RESET_PC(32'h100), .MEM_ADDR_W(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .pc_out(pc_out), .opCode(opc),
`ifdef PERF_CNT_EN
        .cycle_cnt(cc), .instr_cnt(ic),
`endif
        .halted(halted)
    );

    multi_cycle_core #(.RESET_PC(32'h100), .MEM_ADDR_W(32), .TIMEOUT(2)) dut_to (
        .clk(clk), .rst(rst), .bus(tbus), .pc_out(pc_out2), .opCode(opc2),
`ifdef PERF_CNT_EN
        .cycle_cnt(cc2), .instr_cnt(ic2),
`endif
        .halted(halted2)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    logic [31:0] mem  [1024];
    logic [31:0] mmem [1024];
    logic [31:0] wmem [1024];
    bit          wval [1024];
    logic        r_rdy;
    int          cyc = 0;
    int          rmode = 0, stall_init = 0, epoch = 0;
    int          n_chk = 0, n_bad = 0;
    txn_t        log_q[$];
    txn_t        exp_q[$];
    int          viol, hreq, hold800;

    assign bus.mem_ready  = r_rdy;
    assign bus.mem_rdata  = wval[bus.mem_addr[11:2]] ? wmem[bus.mem_addr[11:2]]
                                                      : mem[bus.mem_addr[11:2]];
    assign tbus.mem_ready = 1'b0;
    assign tbus.mem_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder and bus monitor; drives ready mid-cycle, samples 1ns later.
    always @(negedge clk) begin : mon
        txn_t t;
        logic req;
        int   seen, stall_left, nstall;
        logic pend, p_rd, p_wr;
        logic [31:0] p_addr, p_wd;
        if (epoch != seen) begin
            seen = epoch;
            log_q.delete();
            foreach (wval[i]) wval[i] = 1'b0;
            viol = 0; hreq = 0; hold800 = 0;
            stall_left = stall_init;
            pend = 1'b0; nstall = 0;
        end
        req = bus.mem_read | bus.mem_write;
        if (rmode == 0) r_rdy = 1'b1;
        else if (rmode == 1)
            r_rdy = (req && nstall >= 3) ? 1'b1 : ($urandom_range(0, 3) != 0);
        else if (req && bus.mem_addr >= 32'h800 && stall_left > 0) begin
            r_rdy = 1'b0;
            stall_left--;
        end else r_rdy = 1'b1;
        #1;
        if (rst) begin
            if (bus.mem_read && bus.mem_write) viol++;
            if (pend && (bus.mem_read !== p_rd || bus.mem_write !== p_wr ||
                         bus.mem_addr !== p_addr ||
                         (p_wr && bus.mem_wdata !== p_wd))) viol++;
            if (halted && req) hreq++;
            if (bus.mem_read && bus.mem_addr == 32'h800) hold800++;
            if (req && r_rdy) begin
                t.wr   = bus.mem_write;
                t.addr = bus.mem_addr;
                t.data = bus.mem_write ? bus.mem_wdata : bus.mem_rdata;
                t.cyc  = cyc;
                log_q.push_back(t);
                if (bus.mem_write) begin
                    wmem[bus.mem_addr[11:2]] = bus.mem_wdata;
                    wval[bus.mem_addr[11:2]] = 1'b1;
                end
                pend = 1'b0; nstall = 0;
            end else if (req) begin
                pend = 1'b1; nstall++;
                p_rd = bus.mem_read; p_wr = bus.mem_write;
                p_addr = bus.mem_addr; p_wd = bus.mem_wdata;
            end else pend = 1'b0;
        end else begin
            pend = 1'b0; nstall = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    localparam logic [31:0] TRAP_I = 32'hFC00_0000;

    task automatic pw(input logic [31:0] a, input logic [31:0] w);
        mem[a[11:2]] = w;
    endtask

    task automatic clr_mem();
        foreach (mem[i]) mem[i] = 32'h0;
    endtask

    // Architectural interpreter: one instruction per iteration.
    task automatic model_run(input logic [31:0] pc0);
        logic [31:0] r [32];
        logic [31:0] pc, ir, a, b, si, ea;
        logic [4:0]  rs, rt, rd;
        txn_t        t;
        bit          stop;
        foreach (r[i]) r[i] = 32'h0;
        exp_q.delete();
        pc = pc0;
        stop = 0;
        for (int s = 0; s < 3000 && !stop; s++) begin
            ir = mmem[pc[11:2]];
            t.wr = 1'b0; t.addr = pc; t.data = ir; t.cyc = 0;
            exp_q.push_back(t);
            pc = pc + 4;
            rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
            a = r[rs]; b = r[rt];
            si = {{16{ir[15]}}, ir[15:0]};
            case (ir[31:26])
                6'h00: case (ir[5:0])
                    6'h20: r[rd] = a + b;
                    6'h22: r[rd] = a - b;
                    6'h24: r[rd] = a & b;
                    6'h25: r[rd] = a | b;
                    6'h2A: r[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h08: pc = a;
                    default: stop = 1;
                endcase
                6'h08: r[rt] = a + si;
                6'h0A: r[rt] = ($signed(a) < $signed(si)) ? 32'd1 : 32'd0;
                6'h23: begin
                    ea = a + si;
                    t.wr = 1'b0; t.addr = ea; t.data = mmem[ea[11:2]];
                    exp_q.push_back(t);
                    r[rt] = mmem[ea[11:2]];
                end
                6'h2B: begin
                    ea = a + si;
                    t.wr = 1'b1; t.addr = ea; t.data = b;
                    exp_q.push_back(t);
                    mmem[ea[11:2]] = b;
                end
                6'h04: if (a == b) pc = pc + (si << 2);
                6'h05: if (a != b) pc = pc + (si << 2);
                6'h02: pc = {pc[31:28], ir[25:0], 2'b00};
                6'h03: begin
                    r[31] = pc;
                    pc = {pc[31:28], ir[25:0], 2'b00};
                end
                default: stop = 1;
            endcase
            r[0] = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        epoch++;
        rst = 1'b1;
    endtask

    task automatic run_halt(input string tag);
        int n = 0;
        while (!halted && n < 6000) begin
            @(negedge clk); #2;
            n++;
        end
        chk(tag, halted, 1);
        repeat (4) @(negedge clk);
        #2;
        chk("halt_noreq", hreq, 0);
        chk("bus_stable", viol, 0);
    endtask

    task automatic cmp_model();
        int nb;
        chk("tx_count", log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            nb = n_bad;
            chk("tx_wr", log_q[i].wr, exp_q[i].wr);
            chk("tx_addr", log_q[i].addr, exp_q[i].addr);
            chk("tx_data", log_q[i].data, exp_q[i].data);
            if (n_bad != nb) break;
        end
    endtask

    function automatic int find_tx(input logic [31:0] a, input logic w);
        foreach (log_q[i])
            if (log_q[i].addr == a && log_q[i].wr == w) return i;
        return -1;
    endfunction

    task automatic gen_prog();
        logic [31:0] pc;
        logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [4:0]  rs, rt, rd;
        clr_mem();
        for (int k = 0; k < 128; k++) mem[512 + k] = $urandom;
        pc = 32'h100;
        for (int r = 1; r < 32; r++) begin
            pw(pc, ei(6'h08, 5'd0, 5'(r), 16'($urandom))); pc += 4;
        end
        for (int i = 0; i < 40; i++) begin
            rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
            case ($urandom_range(0, 6))
                0, 1: pw(pc, er(rs, rt, rd, fns[$urandom_range(0, 4)]));
                2, 6: pw(pc, ei($urandom_range(0, 1) ? 6'h08 : 6'h0A, rs, rt,
                                16'($urandom)));
                3: pw(pc, ei(6'h23, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 63))));
                4: pw(pc, ei(6'h2B, 5'd0, rt, 16'(32'h800 + 4 * $urandom_range(0, 63))));
                default: pw(pc, ei($urandom_range(0, 1) ? 6'h04 : 6'h05, rs,
                                   $urandom_range(0, 1) ? rs : rt,
                                   16'($urandom_range(1, 2))));
            endcase
            pc += 4;
        end
        for (int r = 1; r < 32; r++) begin
            pw(pc, ei(6'h2B, 5'd0, 5'(r), 16'(32'h900 + 4 * r))); pc += 4;
        end
        pw(pc, TRAP_I);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        // add/addi/sw sequence, zero-wait, plus reset and timeout behaviour
        clr_mem();
        pw(32'h100, ei(6'h08, 5'd0, 5'd1, 16'd5));
        pw(32'h104, ei(6'h08, 5'd0, 5'd2, 16'hFFFD));
        pw(32'h108, er(5'd1, 5'd2, 5'd3, 6'h20));
        pw(32'h10C, ei(6'h2B, 5'd0, 5'd3, 16'd8));
        pw(32'h110, TRAP_I);
        mmem = mem;
        model_run(32'h100);
        rmode = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd", bus.mem_read, 0);
        chk("rst_wr", bus.mem_write, 0);
        chk("rst_halt", halted, 0);
        do_reset();
        @(negedge clk); #2;
        chk("first_rd", bus.mem_read, 1);
        chk("first_addr", bus.mem_addr, 32'h100);
        chk("first_halt", halted, 0);
        chk("to_c1_halt", halted2, 0);
        chk("to_c1_rd", tbus.mem_read, 1);
        @(negedge clk); #2;
        chk("to_c2_halt", halted2, 0);
        @(negedge clk); #2;
        chk("to_c3_halt", halted2, 1);
        chk("to_c3_rd", tbus.mem_read, 0);
        run_halt("halt_p1");
        cmp_model();
        idx = find_tx(32'h8, 1'b1);
        chk("sw_seen", idx >= 0, 1);
        if (idx >= 0) begin
            chk("sw_wdata", log_q[idx].data, 32'd2);
            chk("sw_total_cyc", log_q[idx].cyc - log_q[0].cyc + 1, 16);
        end

        // beq taken / bne not taken, resume after trap
        clr_mem();
        pw(32'h100, 32'h0800_0008);
        pw(32'h020, ei(6'h04, 5'd0, 5'd0, 16'd2));
        pw(32'h02C, ei(6'h05, 5'd0, 5'd0, 16'd5));
        pw(32'h030, TRAP_I);
        mmem = mem;
        model_run(32'h100);
        do_reset();
        @(negedge clk); #2;
        chk("resume_halt", halted, 0);
        chk("resume_addr", bus.mem_addr, 32'h100);
        run_halt("halt_br");
        cmp_model();
        if (log_q.size() >= 4) begin
            chk("br_f1", log_q[1].addr, 32'h20);
            chk("beq_next", log_q[2].addr, 32'h2C);
            chk("bne_next", log_q[3].addr, 32'h30);
            chk("beq_lat", log_q[2].cyc - log_q[1].cyc, 3);
            chk("bne_lat", log_q[3].cyc - log_q[2].cyc, 3);
        end else chk("br_ntx", log_q.size(), 4);

        // jal / jr
        clr_mem();
        pw(32'h100, 32'h0800_0004);
        pw(32'h010, 32'h0C00_0050);
        pw(32'h140, er(5'd31, 5'd0, 5'd0, 6'h08));
        pw(32'h014, TRAP_I);
        mmem = mem;
        model_run(32'h100);
        do_reset();
        run_halt("halt_jal");
        cmp_model();
        if (log_q.size() >= 4) begin
            chk("jal_next", log_q[2].addr, 32'h140);
            chk("jr_next", log_q[3].addr, 32'h14);
            chk("jal_lat", log_q[2].cyc - log_q[1].cyc, 3);
        end else chk("jal_ntx", log_q.size(), 4);

        // lw with three stalled cycles
        clr_mem();
        pw(32'h100, ei(6'h23, 5'd0, 5'd5, 16'h0800));
        pw(32'h104, ei(6'h2B, 5'd0, 5'd5, 16'h0804));
        pw(32'h108, TRAP_I);
        pw(32'h800, 32'hDEAD_BEEF);
        mmem = mem;
        model_run(32'h100);
        rmode = 2;
        stall_init = 3;
        do_reset();
        run_halt("halt_lw");
        cmp_model();
        chk("lw_hold", hold800, 4);
        idx = find_tx(32'h804, 1'b1);
        chk("lw_sw_seen", idx >= 0, 1);
        if (idx >= 0) chk("lw_value", log_q[idx].data, 32'hDEAD_BEEF);
        stall_init = 0;

        // random programs under random ready
        rmode = 1;
        for (int p = 0; p < 5; p++) begin
            gen_prog();
            mmem = mem;
            model_run(32'h100);
            do_reset();
            run_halt("halt_rand");
            cmp_model();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
